// File: rtl/fifo_umbral.sv
// -----------------------------------------------------------------------------
// fifo_umbral
//   Synchronous FIFO with programmable low/high occupancy thresholds. It is the
//   buffer side of the threshold controller. Each channel has one instance. It
//   reports empty, full, almost-empty and almost-full from its occupancy count.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high reset
//   umbral_load   in   capture umbral_LH into the threshold registers
//   umbral_LH     in   packed thresholds: [3:0] low, [7:4] high
//   push          in   write data_in this cycle
//   data_in       in   write data
//   pop           in   read one word this cycle
//   data_out      out  registered read data (one-edge latency)
//   data_valid    out  data_out was updated by an accepted pop at the last edge
//   fifo_empty    out  count == 0
//   fifo_full     out  count == DEPTH
//   almost_empty  out  count <= low threshold
//   almost_full   out  count >= high threshold
//   count         out  number of stored words, 0..DEPTH
//   error         out  sticky overflow/underflow flag, cleared only by reset
// -----------------------------------------------------------------------------
module fifo_umbral #(
    parameter int DATA_WIDTH   = 6,
    parameter int ADDR_WIDTH   = 3,
    parameter int UMBRAL_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    umbral_load,
    input  logic [UMBRAL_WIDTH-1:0] umbral_LH,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid,
    output logic                    fifo_empty,
    output logic                    fifo_full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic [ADDR_WIDTH:0]     count,
    output logic                    error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int TH_W  = UMBRAL_WIDTH / 2;
    // Threshold comparisons are done at the wider of the two operand widths.
    localparam int CMP_W = (TH_W > ADDR_WIDTH + 1) ? TH_W : ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;
    logic                  r_error;
    logic [TH_W-1:0]       r_low;
    logic [TH_W-1:0]       r_high;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic [CMP_W-1:0]      w_count_cmp;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (ADDR_WIDTH+1)'(DEPTH));

    // A push into a full FIFO is still accepted when a pop frees a slot at the
    // same edge. A pop is never served from a same-cycle push.
    assign w_push_ok = push && (!w_full || pop);
    assign w_pop_ok  = pop && !w_empty;

    // Storage. The memory has no reset because its contents are don't-care
    // until they have been written.
    // NOTE: memories are left out of the reset branch so they map onto plain RAM without a reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push_ok && !reset) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Control and status state.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_error      <= 1'b0;
            r_low        <= TH_W'(1);
            r_high       <= TH_W'(DEPTH - 1);
        end else begin
            if (umbral_load) begin
                r_low  <= umbral_LH[TH_W-1:0];
                r_high <= umbral_LH[2*TH_W-1:TH_W];
            end

            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            // The memory read returns the old contents even if the same
            // address is written at this edge.
            if (w_pop_ok) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end
            r_data_valid <= w_pop_ok;

            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if ((push && !w_push_ok) || (pop && !w_pop_ok)) begin
                r_error <= 1'b1;
            end
        end
    end

    assign w_count_cmp  = CMP_W'(r_count);

    assign data_out     = r_data_out;
    assign data_valid   = r_data_valid;
    assign count        = r_count;
    assign error        = r_error;
    assign fifo_empty   = w_empty;
    assign fifo_full    = w_full;
    assign almost_empty = (w_count_cmp <= CMP_W'(r_low));
    assign almost_full  = (w_count_cmp >= CMP_W'(r_high));

endmodule
